// File: rtl/hazard_pkg.sv
// Shared types and default sizes for the multi-cycle hazard unit.
package hazard_pkg;

  localparam int NSRC_DEF    = 3;
  localparam int RW_DEF      = 4;
  localparam int MUL_LAT_DEF = 3;
  localparam int SCW_DEF     = 16;
  localparam int CNT_W       = 4;

  // Forwarding select for one Execute-stage source operand.
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  // Multi-cycle occupancy state, derived from the residency counter.
  typedef enum logic [1:0] {
    MC_IDLE = 2'b00,
    MC_BUSY = 2'b01,
    MC_LAST = 2'b10
  } mc_state_t;

  // Counter value to state: 0 idle, 1 last cycle, anything larger busy.
  function automatic mc_state_t mc_decode(input logic [CNT_W-1:0] cnt);
    if (cnt == '0) begin
      return MC_IDLE;
    end else if (cnt == CNT_W'(1)) begin
      return MC_LAST;
    end else begin
      return MC_BUSY;
    end
  endfunction

endpackage

// File: rtl/hazard_unit_mc_fwd_match.sv
// Forwarding select for a single source operand: Memory beats Writeback,
// and the PC register is never taken from the bypass network.
import hazard_pkg::*;

module fwd_match #(
  parameter int RW = RW_DEF
) (
  input  logic [RW-1:0] src_reg,
  input  logic          src_use,
  input  logic [RW-1:0] dst_m,
  input  logic          wr_m,
  input  logic [RW-1:0] dst_w,
  input  logic          wr_w,
  output fwd_sel_t      sel
);

  localparam logic [RW-1:0] PC_REG = {RW{1'b1}};

  // Pick the youngest producing stage whose destination matches this source.
  always_comb begin
    sel = FWD_RF;
    if (src_use && (src_reg != PC_REG)) begin
      if (wr_m && (dst_m == src_reg)) begin
        sel = FWD_M;
      end else if (wr_w && (dst_w == src_reg)) begin
        sel = FWD_W;
      end
    end
  end

endmodule

// File: rtl/hazard_unit_mc.sv
// Pipeline hazard unit with operand forwarding, load-use stall, a
// multi-cycle Execute occupancy counter, branch/PC-write flushes and a
// saturating stall-cycle counter. Every output except StallCycles is
// combinational from the inputs and the occupancy counter.
import hazard_pkg::*;

module hazard_unit_mc #(
  parameter int NSRC    = NSRC_DEF,
  parameter int RW      = RW_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int SCW     = SCW_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NSRC*RW-1:0]   SrcRegD,
  input  logic [NSRC*RW-1:0]   SrcRegE,
  input  logic [NSRC-1:0]      SrcUseD,
  input  logic [NSRC-1:0]      SrcUseE,
  input  logic [RW-1:0]        DstRegE,
  input  logic [RW-1:0]        DstRegM,
  input  logic [RW-1:0]        DstRegW,
  input  logic                 RegWriteE,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  input  logic                 MemtoRegE,
  input  logic                 MultiE,
  input  logic                 BranchTakenE,
  input  logic                 PCWrPendingF,
  input  logic                 PCSrcW,
  output logic [2*NSRC-1:0]    ForwardE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 FlushM,
  output logic [SCW-1:0]       StallCycles,
  output logic [CNT_W-1:0]     cnt_dbg
);

  // A multi-cycle op only stalls when it needs more than one Execute cycle.
  localparam bit                MUL_MULTI = (MUL_LAT > 1);
  localparam logic [CNT_W-1:0]  MUL_INIT  = CNT_W'(MUL_LAT - 1);
  localparam logic [SCW-1:0]    SC_MAX    = {SCW{1'b1}};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SCW-1:0]   sc_q, sc_d;
  mc_state_t        mc_state;
  logic             mul_stall;
  logic             ldr_stall;
  logic             br_q;
  fwd_sel_t         fwd_sel [NSRC];

  // One forwarding comparator per Execute source.
  for (genvar i = 0; i < NSRC; i++) begin : g_fwd
    fwd_match #(.RW(RW)) u_fwd_match (
      .src_reg (SrcRegE[i*RW +: RW]),
      .src_use (SrcUseE[i]),
      .dst_m   (DstRegM),
      .wr_m    (RegWriteM),
      .dst_w   (DstRegW),
      .wr_w    (RegWriteW),
      .sel     (fwd_sel[i])
    );
    assign ForwardE[2*i +: 2] = fwd_sel[i];
  end

  // Load-use: a Decode source needs the register the Execute load produces.
  always_comb begin
    ldr_stall = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (SrcUseD[i] && (SrcRegD[i*RW +: RW] == DstRegE)) begin
        ldr_stall = 1'b1;
      end
    end
    ldr_stall = ldr_stall & MemtoRegE & RegWriteE;
  end

  // State register: occupancy counter and stall-cycle counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      sc_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sc_q  <= sc_d;
    end
  end

  // Next-state: load residency on a new multi-cycle op, then count down.
  always_comb begin
    mc_state = mc_decode(cnt_q);
    cnt_d    = cnt_q;
    case (mc_state)
      MC_IDLE: if (MultiE && MUL_MULTI) cnt_d = MUL_INIT;
      MC_BUSY: cnt_d = cnt_q - CNT_W'(1);
      MC_LAST: cnt_d = '0;
      default: cnt_d = '0;
    endcase
  end

  // Output decode: the op holds Execute until its final cycle.
  always_comb begin
    mul_stall = 1'b0;
    case (mc_state)
      MC_IDLE: mul_stall = MultiE & MUL_MULTI;
      MC_BUSY: mul_stall = MultiE;
      MC_LAST: mul_stall = 1'b0;
      default: mul_stall = 1'b0;
    endcase
  end

  // Pipeline-register controls; a held Execute register is never flushed.
  always_comb begin
    br_q   = BranchTakenE & ~mul_stall;
    StallE = mul_stall;
    FlushM = mul_stall;
    StallD = ldr_stall | mul_stall;
    StallF = StallD | PCWrPendingF;
    FlushD = br_q | (~StallD & (PCWrPendingF | PCSrcW));
    FlushE = ~mul_stall & (ldr_stall | br_q);
  end

  // Stall-cycle counter saturates instead of wrapping.
  always_comb begin
    sc_d = sc_q;
    if (StallD && (sc_q != SC_MAX)) begin
      sc_d = sc_q + SCW'(1);
    end
  end

  assign StallCycles = sc_q;
  assign cnt_dbg     = cnt_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc. Stimulus pushes the hand-derived
// response into exp_q; a negedge monitor pops and compares it.
module tb_hazard_unit_mc;
  import hazard_pkg::*;

  localparam int W = 36;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [11:0] SrcRegD, SrcRegE;
  logic [2:0]  SrcUseD, SrcUseE;
  logic [3:0]  DstRegE, DstRegM, DstRegW;
  logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MultiE;
  logic        BranchTakenE, PCWrPendingF, PCSrcW;

  logic [5:0]  ForwardE, s4_ForwardE;
  logic        StallF, StallD, StallE, FlushD, FlushE, FlushM;
  logic        s4_StallF, s4_StallD, s4_StallE, s4_FlushD, s4_FlushE, s4_FlushM;
  logic [15:0] StallCycles;
  logic [3:0]  s4_StallCycles;
  logic [3:0]  cnt_dbg, s4_cnt_dbg;

  hazard_unit_mc dut (
    .clk(clk), .reset(reset),
    .SrcRegD(SrcRegD), .SrcRegE(SrcRegE), .SrcUseD(SrcUseD), .SrcUseE(SrcUseE),
    .DstRegE(DstRegE), .DstRegM(DstRegM), .DstRegW(DstRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MultiE(MultiE), .BranchTakenE(BranchTakenE),
    .PCWrPendingF(PCWrPendingF), .PCSrcW(PCSrcW),
    .ForwardE(ForwardE), .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .StallCycles(StallCycles), .cnt_dbg(cnt_dbg)
  );

  hazard_unit_mc #(.SCW(4)) dut_s4 (
    .clk(clk), .reset(reset),
    .SrcRegD(SrcRegD), .SrcRegE(SrcRegE), .SrcUseD(SrcUseD), .SrcUseE(SrcUseE),
    .DstRegE(DstRegE), .DstRegM(DstRegM), .DstRegW(DstRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MultiE(MultiE), .BranchTakenE(BranchTakenE),
    .PCWrPendingF(PCWrPendingF), .PCSrcW(PCSrcW),
    .ForwardE(s4_ForwardE), .StallF(s4_StallF), .StallD(s4_StallD), .StallE(s4_StallE),
    .FlushD(s4_FlushD), .FlushE(s4_FlushE), .FlushM(s4_FlushM),
    .StallCycles(s4_StallCycles), .cnt_dbg(s4_cnt_dbg)
  );

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  sample_req = 1'b0;
  bit  done = 1'b0;
  int  exp_sc16 = 0;
  int  exp_sc4 = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare the presented outputs against the oldest expectation.
  always @(negedge clk) begin
    if (sample_req) begin
      logic [W-1:0] e;
      sample_req = 1'b0;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow: got empty queue expected an entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("forward_e",       16'(ForwardE),        16'(e[35:30]));
        check("stall_flush",     16'({StallF, StallD, StallE, FlushD, FlushE, FlushM}), 16'(e[29:24]));
        check("mc_cnt",          16'(cnt_dbg),         16'(e[23:20]));
        check("stall_cycles",    StallCycles,          e[19:4]);
        check("stall_cycles_s4", 16'(s4_StallCycles),  16'(e[3:0]));
      end
    end
  end

  // Driver tasks
  task automatic clear_inputs();
    SrcRegD = '0; SrcRegE = '0; SrcUseD = '0; SrcUseE = '0;
    DstRegE = '0; DstRegM = '0; DstRegW = '0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemtoRegE = 1'b0; MultiE = 1'b0;
    BranchTakenE = 1'b0; PCWrPendingF = 1'b0; PCSrcW = 1'b0;
  endtask

  // ctl order: {StallF, StallD, StallE, FlushD, FlushE, FlushM}
  task automatic expect_cycle(input logic [5:0] fwd, input logic [5:0] ctl, input logic [3:0] cnt);
    exp_q.push_back({fwd, ctl, cnt, 16'(exp_sc16), 4'(exp_sc4)});
    sample_req = 1'b1;
    @(posedge clk);
    if (!reset) begin
      exp_sc16 = 0;
      exp_sc4  = 0;
    end else if (ctl[4]) begin
      if (exp_sc16 < 65535) exp_sc16++;
      if (exp_sc4 < 15) exp_sc4++;
    end
    #1;
  endtask

  task automatic set_ldr_hazard();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; DstRegE = 4'd5;
    SrcRegD[7:4] = 4'd5; SrcUseD = 3'b010;
  endtask

  // Stimulus
  initial begin
    reset = 1'b0;
    clear_inputs();
    @(posedge clk); #1;
    expect_cycle(6'b000000, 6'b000000, 4'd0);
    reset = 1'b1;
    expect_cycle(6'b000000, 6'b000000, 4'd0);

    // Forwarding: M over W, W alone, PC never forwards
    SrcRegE[3:0] = 4'd3; SrcUseE = 3'b001;
    DstRegM = 4'd3; RegWriteM = 1'b1; DstRegW = 4'd3; RegWriteW = 1'b1;
    expect_cycle(6'b000010, 6'b000000, 4'd0);
    RegWriteM = 1'b0;
    expect_cycle(6'b000001, 6'b000000, 4'd0);
    SrcRegE[3:0] = 4'd15; DstRegM = 4'd15; DstRegW = 4'd15; RegWriteM = 1'b1;
    expect_cycle(6'b000000, 6'b000000, 4'd0);
    SrcRegE = {4'd7, 4'd9, 4'd3}; SrcUseE = 3'b111;
    DstRegM = 4'd9; DstRegW = 4'd7;
    expect_cycle(6'b011000, 6'b000000, 4'd0);

    // Load-use stall and its non-triggers
    clear_inputs(); set_ldr_hazard();
    expect_cycle(6'b000000, 6'b110010, 4'd0);
    SrcUseD = 3'b001;
    expect_cycle(6'b000000, 6'b000000, 4'd0);
    SrcUseD = 3'b010; RegWriteE = 1'b0;
    expect_cycle(6'b000000, 6'b000000, 4'd0);

    // PC-write pending / PC source at W
    clear_inputs(); PCWrPendingF = 1'b1;
    expect_cycle(6'b000000, 6'b100100, 4'd0);
    clear_inputs(); PCSrcW = 1'b1;
    expect_cycle(6'b000000, 6'b000100, 4'd0);
    clear_inputs(); set_ldr_hazard(); PCWrPendingF = 1'b1;
    expect_cycle(6'b000000, 6'b110010, 4'd0);
    clear_inputs(); BranchTakenE = 1'b1;
    expect_cycle(6'b000000, 6'b000110, 4'd0);

    // Multi-cycle op, MUL_LAT=3
    clear_inputs(); MultiE = 1'b1;
    expect_cycle(6'b000000, 6'b111001, 4'd0);
    expect_cycle(6'b000000, 6'b111001, 4'd2);
    expect_cycle(6'b000000, 6'b000000, 4'd1);
    MultiE = 1'b0;
    expect_cycle(6'b000000, 6'b000000, 4'd0);

    // Branch suppressed while Execute is held, honoured on the last cycle
    MultiE = 1'b1; BranchTakenE = 1'b1;
    expect_cycle(6'b000000, 6'b111001, 4'd0);
    expect_cycle(6'b000000, 6'b111001, 4'd2);
    expect_cycle(6'b000000, 6'b000110, 4'd1);
    clear_inputs();
    expect_cycle(6'b000000, 6'b000000, 4'd0);

    // Load-use during a multi-cycle hold: no Execute flush until released
    MultiE = 1'b1; set_ldr_hazard();
    expect_cycle(6'b000000, 6'b111001, 4'd0);
    expect_cycle(6'b000000, 6'b111001, 4'd2);
    expect_cycle(6'b000000, 6'b110010, 4'd1);
    clear_inputs();
    expect_cycle(6'b000000, 6'b000000, 4'd0);

    // Reset in the middle of BUSY
    MultiE = 1'b1;
    expect_cycle(6'b000000, 6'b111001, 4'd0);
    reset = 1'b0;
    expect_cycle(6'b000000, 6'b111001, 4'd2);
    reset = 1'b1; MultiE = 1'b0;
    expect_cycle(6'b000000, 6'b000000, 4'd0);

    // Stall counter saturation (16-bit keeps counting, 4-bit holds at 15)
    set_ldr_hazard();
    for (int i = 0; i < 20; i++) begin
      expect_cycle(6'b000000, 6'b110010, 4'd0);
    end
    clear_inputs();
    expect_cycle(6'b000000, 6'b000000, 4'd0);

    @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    if (!done) begin
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

endmodule
